// File: rtl/servo_slew_pwm.sv
// Slew-limited hobby-servo pulse generator.
// Latches a target position and walks the driven position toward it by at
// most SLEW_STEP per frame. Each frame emits one pulse whose width is
// MIN_PULSE + current_pos * PULSE_STEP clocks.
module servo_slew_pwm #(
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter int unsigned MIN_PULSE     = 50000,
    parameter int unsigned PULSE_STEP    = 196,
    parameter int unsigned SLEW_STEP     = 4,
    parameter int unsigned CENTER        = 128
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] target_pos,
    input  logic       target_valid,
    output logic       servo_PWM,
    output logic [7:0] current_pos,
    output logic       frame_tick,
    output logic       settled
);

    localparam logic [19:0] LAST_COUNT = 20'(PERIOD_CYCLES - 1);
    localparam logic [7:0]  CENTER_POS = 8'(CENTER);
    localparam logic [8:0]  STEP9      = 9'(SLEW_STEP);
    localparam logic [7:0]  STEP8      = 8'(SLEW_STEP);

    logic [19:0] counter;
    logic [19:0] pulse_len;
    logic [7:0]  target_q;
    logic [7:0]  next_pos;
    logic [8:0]  diff;
    logic [8:0]  mag;
    logic        frame_end;

    function automatic logic [19:0] pulse_for(input logic [7:0] pos);
        return 20'(MIN_PULSE) + 20'(pos) * 20'(PULSE_STEP);
    endfunction

    assign frame_end = (counter == LAST_COUNT);

    // Next position: jump when within one step (or unlimited), else step toward target.
    always_comb begin
        diff     = {1'b0, target_q} - {1'b0, current_pos};
        mag      = diff[8] ? (9'd0 - diff) : diff;
        next_pos = target_q;
        if ((SLEW_STEP != 0) && (mag > STEP9)) begin
            if (diff[8]) begin
                next_pos = current_pos - STEP8;
            end else begin
                next_pos = current_pos + STEP8;
            end
        end
    end

    // Frame counter, wraps at PERIOD_CYCLES-1 and marks the frame start.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            counter    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            counter    <= frame_end ? '0 : counter + 20'd1;
        end
    end

    // Target latch; a strobe on the frame-start edge is seen only next frame.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            target_q <= CENTER_POS;
        end else if (target_valid) begin
            target_q <= target_pos;
        end
    end

    // Position and pulse width update together once per frame.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            current_pos <= CENTER_POS;
            pulse_len   <= pulse_for(CENTER_POS);
        end else if (frame_end) begin
            current_pos <= next_pos;
            pulse_len   <= pulse_for(next_pos);
        end
    end

    // Registered pulse output; the width register only changes at the wrap,
    // so each frame's pulse uses a single width.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            servo_PWM <= 1'b0;
        end else begin
            servo_PWM <= (counter < pulse_len);
        end
    end

    assign settled = (current_pos == target_q);

endmodule

// File: tb/tb_servo_slew_pwm.sv
// Directed bench for servo_slew_pwm with shortened frames.
// Instance A: slew-limited (period 1000, min 200, step 3, slew 4).
// Instance B: unlimited slew (period 2000, min 500, step 4).
module tb_servo_slew_pwm;

    localparam int PA = 1000;
    localparam int PB = 2000;

    logic       clk;
    logic       rst_a, rst_b;
    logic [7:0] tpos_a, tpos_b;
    logic       tval_a, tval_b;
    logic       pwm_a, pwm_b;
    logic [7:0] cur_a, cur_b;
    logic       tick_a, tick_b;
    logic       set_a, set_b;

    int checks = 0;
    int errors = 0;

    servo_slew_pwm #(
        .PERIOD_CYCLES(PA), .MIN_PULSE(200), .PULSE_STEP(3),
        .SLEW_STEP(4), .CENTER(128)
    ) dut_a (
        .CLOCK_50(clk), .reset(rst_a), .target_pos(tpos_a), .target_valid(tval_a),
        .servo_PWM(pwm_a), .current_pos(cur_a), .frame_tick(tick_a), .settled(set_a)
    );

    servo_slew_pwm #(
        .PERIOD_CYCLES(PB), .MIN_PULSE(500), .PULSE_STEP(4),
        .SLEW_STEP(0), .CENTER(128)
    ) dut_b (
        .CLOCK_50(clk), .reset(rst_b), .target_pos(tpos_b), .target_valid(tval_b),
        .servo_PWM(pwm_b), .current_pos(cur_b), .frame_tick(tick_b), .settled(set_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Wait for the next frame tick, bounded to just over one frame.
    task automatic wait_tick(input bit sel);
        int n = 0;
        logic t;
        do begin
            @(negedge clk);
            n++;
            t = sel ? tick_b : tick_a;
        end while (!t && n < (sel ? PB : PA) + 5);
        check(sel ? "tick_b" : "tick_a", 32'(t), 1);
    endtask

    // Count high samples over one full frame; ends on the next tick sample.
    task automatic measure(input bit sel, output int w);
        w = 0;
        for (int i = 0; i < (sel ? PB : PA); i++) begin
            @(negedge clk);
            if (sel ? pwm_b : pwm_a) w++;
        end
    endtask

    task automatic strobe_a(input logic [7:0] v);
        tpos_a = v;
        tval_a = 1'b1;
        @(negedge clk);
        tval_a = 1'b0;
    endtask

    initial begin
        int w;
        int exp;
        rst_a = 1'b1; rst_b = 1'b1;
        tpos_a = '0; tpos_b = '0;
        tval_a = 1'b0; tval_b = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(pwm_a), 0);
        check("rst_cur", 32'(cur_a), 128);
        check("rst_settled", 32'(set_a), 1);
        check("rst_tick", 32'(tick_a), 0);

        // Idle after release
        rst_a = 1'b0;
        @(negedge clk);
        check("first_edge_pwm", 32'(pwm_a), 1);
        wait_tick(0);
        @(negedge clk);
        check("tick_one_cycle", 32'(tick_a), 0);
        wait_tick(0);
        measure(0, w);
        check("idle_pulse", 32'(w), 584);
        check("idle_period_tick", 32'(tick_a), 1);
        check("idle_cur", 32'(cur_a), 128);
        check("idle_settled", 32'(set_a), 1);

        // Slew up to 200
        repeat (100) @(negedge clk);
        strobe_a(8'd200);
        check("up_unsettled", 32'(set_a), 0);
        for (int k = 1; k <= 18; k++) begin
            wait_tick(0);
            exp = 128 + 4 * k;
            check("up_cur", 32'(cur_a), 32'(exp));
            check("up_settled", 32'(set_a), (k == 18) ? 1 : 0);
        end
        measure(0, w);
        check("up_pulse", 32'(w), 800);

        // Full travel from 130 to 0
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (50) @(negedge clk);
        strobe_a(8'd130);
        wait_tick(0);
        check("down_start", 32'(cur_a), 130);
        repeat (50) @(negedge clk);
        strobe_a(8'd0);
        for (int k = 1; k <= 33; k++) begin
            wait_tick(0);
            exp = (130 - 4 * k < 0) ? 0 : 130 - 4 * k;
            check("down_cur", 32'(cur_a), 32'(exp));
        end
        check("down_settled", 32'(set_a), 1);
        measure(0, w);
        check("down_pulse", 32'(w), 200);
        check("down_no_underflow", 32'(cur_a), 0);

        // Two strobes in one frame: last wins
        repeat (50) @(negedge clk);
        strobe_a(8'd10);
        repeat (20) @(negedge clk);
        strobe_a(8'd250);
        for (int k = 1; k <= 3; k++) begin
            wait_tick(0);
            check("last_wins_cur", 32'(cur_a), 32'(4 * k));
        end
        repeat (50) @(negedge clk);
        strobe_a(8'd12);
        wait_tick(0);
        check("hold_cur", 32'(cur_a), 12);
        check("hold_settled", 32'(set_a), 1);

        // Strobe on the frame-start edge is deferred one frame
        repeat (PA - 1) @(negedge clk);
        tpos_a = 8'd255;
        tval_a = 1'b1;
        @(negedge clk);
        tval_a = 1'b0;
        check("edge_tick", 32'(tick_a), 1);
        check("edge_cur_unchanged", 32'(cur_a), 12);
        check("edge_unsettled", 32'(set_a), 0);
        wait_tick(0);
        check("edge_next_cur", 32'(cur_a), 16);

        // Reset mid-pulse while slewing
        repeat (10) @(negedge clk);
        check("mid_pwm_high", 32'(pwm_a), 1);
        @(posedge clk);
        #2 rst_a = 1'b1;
        #1;
        check("async_pwm", 32'(pwm_a), 0);
        check("async_cur", 32'(cur_a), 128);
        check("async_settled", 32'(set_a), 1);
        @(negedge clk);
        rst_a = 1'b0;
        measure(0, w);
        check("post_rst_pulse", 32'(w), 584);
        check("post_rst_tick", 32'(tick_a), 1);

        // Unlimited slew jumps in one frame
        rst_a = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        wait_tick(1);
        repeat (100) @(negedge clk);
        tpos_b = 8'd255;
        tval_b = 1'b1;
        @(negedge clk);
        tval_b = 1'b0;
        check("b_unsettled", 32'(set_b), 0);
        wait_tick(1);
        check("b_cur", 32'(cur_b), 255);
        check("b_settled", 32'(set_b), 1);
        measure(1, w);
        check("b_pulse", 32'(w), 1520);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_slew_pwm.md
# servo_slew_pwm

Slew-limited servo pulse generator that sits directly downstream of the sentry command state machine and replaces the bare position-to-PWM stage. It latches an 8-bit target position, moves an internal current position toward it by at most a fixed step per 20 ms servo frame, and emits a standard 1–2 ms hobby-servo pulse for that position. The result is a mechanically gentle pan motion regardless of how abruptly UART commands change the target.

## Interface
- PERIOD_CYCLES, 1000000: clocks per servo frame (20 ms at 50 MHz).
- MIN_PULSE, 50000: pulse width for position 0 (1 ms).
- PULSE_STEP, 196: extra pulse clocks per position LSB (position 255 gives 99980).
- SLEW_STEP, 4: maximum change of current position per frame; 0 means no limiting (jump to target).
- CENTER, 128: position loaded at reset.
- Constraint: MIN_PULSE + 255*PULSE_STEP < PERIOD_CYCLES; counter and pulse registers are 20 bits.
- CLOCK_50  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- target_pos  input  8  requested position (0 = full left, 255 = full right).
- target_valid  input  1  single-cycle strobe; latches target_pos on that edge.
- servo_PWM  output  1  registered servo pulse.
- current_pos  output  8  position currently being driven.
- frame_tick  output  1  one-cycle pulse at each frame start.
- settled  output  1  high when current_pos == latched target.

## Operation
- Frame counter: 0 to PERIOD_CYCLES-1, increments every clock, wraps to 0.
- Frame-start edge: the edge where the counter wraps from PERIOD_CYCLES-1 to 0. On that edge:
  - current_pos is updated from the target register value held before the edge.
  - pulse_len <= MIN_PULSE + new_current_pos*PULSE_STEP.
  - frame_tick <= 1 for that one cycle.
- Slew rule (9-bit signed diff = target - current):
  - |diff| <= SLEW_STEP, or SLEW_STEP == 0: current = target.
  - Otherwise current moves toward target by exactly SLEW_STEP.
  - No wrap-around; values saturate within 0–255 by construction.
- Target register:
  - Updates on any edge with target_valid = 1.
  - Multiple strobes in one frame: the last one wins.
  - A strobe on the frame-start edge itself is not used by that edge's update; it takes effect at the next frame.
- PWM: servo_PWM <= (counter < pulse_len), registered. A new pulse_len takes effect from the first cycle of the new frame, so a frame never mixes two widths.
- settled is combinational: (current_pos == target register).

## Timing
- Reset values:
  - counter = 0, target = current_pos = CENTER.
  - pulse_len = MIN_PULSE + CENTER*PULSE_STEP (75088 with defaults).
  - servo_PWM = 0, frame_tick = 0, settled = 1.
- After reset release:
  - The first edge registers servo_PWM = 1.
  - The pulse is high for exactly pulse_len consecutive cycles per frame, then low until the next frame.
  - The pulse's rising edge is 1 cycle after counter == 0.
- Latency: a target strobed mid-frame first affects the pulse starting at the next frame boundary (max latency 1 frame + 1 cycle).
- Settling time = ceil(|target - current| / SLEW_STEP) frames.
- Reset asserted mid-pulse: servo_PWM drops to 0 asynchronously and all state returns to reset values.

## Test plan
- Reset and idle:
  - Release reset with no strobes.
  - Expect servo_PWM high for 75088 cycles every 1000000 cycles, current_pos = 128, settled = 1, and frame_tick once per frame.
- Slew up:
  - Strobe target_pos = 200 mid-frame.
  - Expect current_pos 132, 136, … at successive frame ticks, reaching 200 after 18 frames.
  - Expect settled to rise on the 18th tick and the final pulse = 89200 cycles.
- Full travel and sub-step tail:
  - Strobe target_pos = 0 from 130.
  - Expect a last step of 2 (6 → 4 → 0 is not allowed; 2 → 0 is), reaching 0 after 33 frames with pulse = 50000.
  - Expect no underflow.
- Strobe collisions:
  - Strobe 10 then 250 within one frame: expect movement toward 250 only.
  - Strobe 255 on the frame-start edge: expect no change that frame and movement starting the following frame.
- SLEW_STEP = 0 (reduced PERIOD_CYCLES = 2000, MIN_PULSE = 500, PULSE_STEP = 4):
  - Strobe 255.
  - Expect current_pos = 255 at the next tick and pulse = 1520 cycles.
- Reset mid-operation:
  - Assert reset during a high pulse while slewing.
  - Expect servo_PWM = 0 in the same cycle and current_pos = 128.
  - Expect the next pulse after release to be 75088 cycles.
